// File: rtl/minisys_md_pkg.sv
// Minisys1A multiply/divide unit: shared encodings and helpers.
// Operation codes, FSM states and the iteration count.
package minisys_md_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } md_state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return !op[2];
    endfunction

    function automatic logic [31:0] abs32(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/minisys_mdu_md_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: add-shift. Divide: restoring trial subtract.
module md_step (
    input  logic        mul,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] trial;
    logic [31:0] diff;
    logic        ge;

    // Single step: acc[63:32] is the upper product / partial remainder.
    always_comb begin
        sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        trial = {acc[63:32], acc[31]};
        ge    = (trial >= {1'b0, opnd});
        diff  = trial[31:0] - opnd;
        if (mul)
            acc_next = {sum, acc[31:1]};
        else if (ge)
            acc_next = {diff, acc[30:0], 1'b1};
        else
            acc_next = {trial[31:0], acc[30:0], 1'b0};
    end

endmodule

// File: rtl/minisys_mdu.sv
// Minisys1A iterative multiply/divide unit with HI/LO.
// 32 steps, a sign-fix cycle, then HI/LO update.
module minisys_mdu
    import minisys_md_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        mf_req,
    input  logic        flush,
    output logic        busy,
    output logic        md_pause,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      acc_q, acc_step;
    logic [31:0]      opnd_q;
    logic             is_mul_q, neg_q, rem_neg_q, div0_q;
    logic             busy_q, done_q;
    logic [31:0]      hi_q, lo_q;

    logic             idle_req, accept, wr_hi, wr_lo;
    logic             run_step, fix_write;
    logic             op_mul, op_signed;
    logic [31:0]      abs_a, abs_b;
    logic [63:0]      prod_fix;
    logic [31:0]      quo_fix, rem_fix, res_hi, res_lo;

    md_step u_step (
        .mul      (is_mul_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    // Request decode: only an unflushed IDLE cycle takes a request.
    always_comb begin
        idle_req  = (state_q == S_IDLE) && md_valid && !flush;
        op_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
        op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
        abs_a     = abs32(md_a, op_signed);
        abs_b     = abs32(md_b, op_signed);
        accept    = idle_req && is_arith(md_op);
        wr_hi     = idle_req && (md_op == OP_MTHI);
        wr_lo     = idle_req && (md_op == OP_MTLO);
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and step/writeback enables.
    always_comb begin
        state_d   = state_q;
        run_step  = 1'b0;
        fix_write = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    run_step = 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d   = S_IDLE;
                fix_write = !flush;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sign correction; divide by zero forces an all-ones quotient.
    always_comb begin
        prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
        rem_fix  = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        if (div0_q)
            quo_fix = 32'hFFFF_FFFF;
        else if (neg_q)
            quo_fix = 32'd0 - acc_q[31:0];
        else
            quo_fix = acc_q[31:0];
        res_hi = is_mul_q ? prod_fix[63:32] : rem_fix;
        res_lo = is_mul_q ? prod_fix[31:0] : quo_fix;
    end

    // Datapath: operand latch on accept, one step per RUN cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_mul_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            acc_q     <= {32'd0, op_mul ? abs_b : abs_a};
            opnd_q    <= op_mul ? abs_a : abs_b;
            is_mul_q  <= op_mul;
            neg_q     <= op_signed && (md_a[31] ^ md_b[31]);
            rem_neg_q <= op_signed && md_a[31];
            div0_q    <= !op_mul && (md_b == 32'd0);
        end else if (run_step) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_step;
        end
    end

    // Status flags are registered so busy/done are glitch-free.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= fix_write;
        end
    end

    // Architectural HI/LO: moves from GPRs or the finished result.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_write) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else begin
            if (wr_hi)
                hi_q <= md_a;
            if (wr_lo)
                lo_q <= md_a;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_pause = busy_q & (md_valid | mf_req);

endmodule

// File: tb/tb_minisys_mdu.sv
// Self-checking bench for minisys_mdu.
// Random ops against an arithmetic reference model.
module tb_minisys_mdu;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        md_valid = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] md_a = '0;
    logic [31:0] md_b = '0;
    logic        mf_req = 1'b0;
    logic        flush = 1'b0;
    logic        busy, md_pause, done;
    logic [31:0] hi, lo;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    minisys_mdu dut (
        .clk      (clk),
        .clrn     (clrn),
        .md_valid (md_valid),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .mf_req   (mf_req),
        .flush    (flush),
        .busy     (busy),
        .md_pause (md_pause),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_md(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            3'd0: begin
                sq = sa * sb;
                r  = sq;
            end
            3'd1: r = ua * ub;
            3'd2: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else
                    r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        md_valid = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        tick();
        md_valid = 1'b0;
    endtask

    // n = cycles from the accept edge until done is seen (capped).
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (2) tick();
        nchk++;
        if ({busy, done, md_pause, hi, lo} !== '0) begin
            nerr++;
            $display("FAIL reset_state: got busy=%b done=%b pause=%b hi=%h lo=%h, want all 0",
                     busy, done, md_pause, hi, lo);
        end
        #2 clrn = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2};
        logic [31:0] as  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'd100, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bs  [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0,
                                 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ehs [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'd100, 32'd0, 32'hFFFF_FFF9};
        logic [31:0] els [6] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        int n;
        for (int i = 0; i < 6; i++) begin
            start_op(ops[i], as[i], bs[i]);
            nchk++;
            if (busy !== 1'b1) begin
                nerr++;
                $display("FAIL dir_busy_%0d: got %b want 1", i, busy);
            end
            wait_done(n);
            nchk++;
            if (n != 34 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL dir_latency_%0d: got %0d busy=%b want 34 busy=0",
                         i, n, busy);
            end
            nchk++;
            if (hi !== ehs[i] || lo !== els[i]) begin
                nerr++;
                $display("FAIL dir_result_%0d: got hi=%h lo=%h want hi=%h lo=%h",
                         i, hi, lo, ehs[i], els[i]);
            end
            exp_hi = ehs[i];
            exp_lo = els[i];
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] r;
        int n;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            start_op(op, a, b);
            if (op == 3'd4) begin
                exp_hi = a;
            end else if (op == 3'd5) begin
                exp_lo = a;
            end else begin
                wait_done(n);
                nchk++;
                if (n != 34) begin
                    nerr++;
                    $display("FAIL rnd_latency_%0d: got %0d want 34", i, n);
                end
                r = ref_md(op, a, b);
                exp_hi = r[63:32];
                exp_lo = r[31:0];
            end
            nchk++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                nerr++;
                $display("FAIL rnd_%0d op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         i, op, a, b, hi, lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_flush();
        int dones = 0;
        start_op(3'd4, 32'h1234, 32'd0);
        start_op(3'd5, 32'hABCD_0000, 32'd0);
        exp_hi = 32'h1234;
        exp_lo = 32'hABCD_0000;
        start_op(3'd0, 32'd5, 32'd6);
        for (int k = 1; k < 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nchk++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            nerr++;
            $display("FAIL flush_run: got busy=%b hi=%h lo=%h want 0 %h %h",
                     busy, hi, lo, exp_hi, exp_lo);
        end
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        nchk++;
        if (dones != 0 || hi !== exp_hi || lo !== exp_lo) begin
            nerr++;
            $display("FAIL flush_nodone: got dones=%0d hi=%h lo=%h want 0 %h %h",
                     dones, hi, lo, exp_hi, exp_lo);
        end
        flush = 1'b1;
        start_op(3'd5, 32'hDEAD, 32'd0);
        flush = 1'b0;
        nchk++;
        if (lo !== exp_lo || busy !== 1'b0) begin
            nerr++;
            $display("FAIL flush_idle: got lo=%h busy=%b want %h 0", lo, busy, exp_lo);
        end
        start_op(3'd5, 32'hDEAD, 32'd0);
        exp_lo = 32'hDEAD;
        nchk++;
        if (lo !== exp_lo) begin
            nerr++;
            $display("FAIL mtlo_after: got %h want %h", lo, exp_lo);
        end
    endtask

    task automatic test_bad_op();
        for (int o = 6; o < 8; o++) begin
            start_op(3'(o), 32'h5555_AAAA, 32'd3);
            tick();
            nchk++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
                nerr++;
                $display("FAIL bad_op_%0d: got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                         o, busy, done, hi, lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int bad = 0;
        int n;
        start_op(3'd2, 32'd1000, 32'd7);
        md_valid = 1'b1;
        md_op    = 3'd0;
        md_a     = 32'hFFFF_FFFD;
        md_b     = 32'd7;
        mf_req   = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            if (md_pause !== 1'b1) bad++;
            tick();
        end
        nchk++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL pause_hold: got %0d cycles without pause want 0", bad);
        end
        nchk++;
        if (md_pause !== 1'b0 || done !== 1'b1 || hi !== 32'd6 || lo !== 32'd142) begin
            nerr++;
            $display("FAIL done_cycle: got pause=%b done=%b hi=%h lo=%h want 0 1 6 8e",
                     md_pause, done, hi, lo);
        end
        tick();
        md_valid = 1'b0;
        mf_req   = 1'b0;
        nchk++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        wait_done(n);
        r = ref_md(3'd0, 32'hFFFF_FFFD, 32'd7);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        nchk++;
        if (n != 34 || hi !== exp_hi || lo !== exp_lo) begin
            nerr++;
            $display("FAIL b2b_result: got n=%0d hi=%h lo=%h want 34 %h %h",
                     n, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_async_reset();
        int n;
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) tick();
        mf_req = 1'b1;
        #2 clrn = 1'b0;
        #1;
        nchk++;
        if ({busy, done, md_pause, hi, lo} !== '0) begin
            nerr++;
            $display("FAIL async_reset: got busy=%b done=%b pause=%b hi=%h lo=%h want all 0",
                     busy, done, md_pause, hi, lo);
        end
        mf_req = 1'b0;
        tick();
        #2 clrn = 1'b1;
        tick();
        start_op(3'd0, 32'd7, 32'd9);
        wait_done(n);
        nchk++;
        if (n != 34 || hi !== 32'd0 || lo !== 32'd63) begin
            nerr++;
            $display("FAIL post_reset_mult: got n=%0d hi=%h lo=%h want 34 0 3f",
                     n, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_bad_op();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
